spr_rom_sched: RTL and testbench
================================

// Module: spr_rom_sched
// PURPOSE
//  Sequences the shared external ROM port (SDRAM controller) between sprite-ROM fetches, tile-ROM fetches and
//  MiSTer ioctl download writes. Sprite side is address-driven (spr_addr changes, no strobe); block detects the change,
//  fetches the 32-bit word, holds it stable on spr_dout. Sits between the sprites block and the SDRAM controller.
// PARAMETERS
//  SPR_BASE   26'h0100000  byte offset of sprite ROM region in external memory
//  TILE_BASE  26'h0000000  byte offset of tile ROM region
// PORTS
//  clk        in   1   system clock
//  nRES       in   1   asynchronous reset, active low
//  dl_active  in   1   ioctl_download in progress
//  dl_we      in   1   download write strobe (1 cycle)
//  dl_addr    in   26  download byte address (bit 0 ignored)
//  dl_data    in   16  download write data
//  dl_ready   out  1   high when a dl_we will be accepted
//  spr_addr   in   19  sprite ROM word address (32-bit words)
//  spr_dout   out  32  sprite ROM data for current spr_addr
//  spr_valid  out  1   spr_dout matches current spr_addr
//  tile_req   in   1   tile fetch request (level, held until tile_ack)
//  tile_addr  in   20  tile ROM word address
//  tile_dout  out  32  tile data, valid when tile_ack
//  tile_ack   out  1   1-cycle pulse, tile_dout valid
//  mem_req    out  1   request to memory; held until mem_ack
//  mem_we     out  1   1 = write (16-bit), 0 = read (32-bit)
//  mem_addr   out  26  byte address
//  mem_wdata  out  16  write data
//  mem_ack    in   1   request accepted (1 cycle)
//  mem_rvalid in   1   read data valid (1 cycle, >=1 cycle after mem_ack, in order, max 1 outstanding)
//  mem_rdata  in   32  read data
// BEHAVIOUR
//  - Reset: all outputs 0 (spr_dout/tile_dout 0, spr_valid 0, dl_ready 0); FSM IDLE; internal last-addr tag invalid.
//  - FSM: IDLE -> ISSUE (mem_req=1, fields registered) -> on mem_ack: write -> IDLE; read -> WAIT -> on mem_rvalid -> IDLE.
//  - Address: sprite {spr_addr,2'b00}+SPR_BASE; tile {tile_addr,2'b00}+TILE_BASE; download {dl_addr[25:1],1'b0}. Sums mod 2^26.
//  - Priority in IDLE: dl_active -> download only (sprite/tile requests stall, no reads issued); else round-robin
//    sprite/tile, pointer flips to the other channel after each granted read; sole requester always granted.
//  - Download: dl_ready=1 only in IDLE with dl_active; dl_we latched into 1-entry buffer; dl_ready=0 until mem_ack.
//    dl_we while dl_ready=0 is a protocol error: dropped, not queued.
//  - Sprite request pending when spr_addr != tag or tag invalid. spr_valid combinationally 0 the cycle spr_addr
//    differs from tag. On mem_rvalid for a sprite read: spr_dout<=mem_rdata, tag<=issued addr, spr_valid=1 next cycle if
//    spr_addr still equal; if spr_addr changed during fetch, data still stored under issued tag, new fetch queued.
//  - Tile: tile_ack pulses the cycle after mem_rvalid; tile_req dropped before ack -> read completes, ack suppressed.
//  - Latency (idle, mem_ack same cycle as req, rvalid next): addr change -> spr_valid at +3 cycles.
//  - dl_active falling edge: tag invalidated (ROM contents changed).
//  - Reset mid-operation: FSM aborts, mem_req drops async; memory controller shares nRES, late rvalid ignored.
// CONFIGURATION
//  SPR_PREFETCH_EN defined: second 32-bit buffer + tag; after a sprite read completes with FSM IDLE, no tile_req
//   and no dl_active, issue read for tag+1 (19-bit wrap 7FFFF->00000). spr_addr hitting prefetch tag: swap buffers,
//   spr_valid next cycle, no memory access. Prefetch is lowest priority, never preempts; invalidated with main tag.
//  Undefined: single buffer, no speculative reads; mem traffic only on demand.
// STRUCTURE
//  Package spr_rom_pkg: FSM state enum (IDLE, ISSUE, WAIT), channel enum (CH_DL, CH_SPR, CH_TILE, CH_PF),
//   address widths (SPR_AW=19, TILE_AW=20, MEM_AW=26).
//  Sub-module spr_rom_line: tag + data register + compare (instantiated twice with SPR_PREFETCH_EN).
// TESTING
//  1 spr_addr 0->0x00010, mem rdata 0xDEADBEEF -> mem_addr=SPR_BASE+0x40, spr_valid at +3, spr_dout=DEADBEEF.
//  2 tile_req + sprite change same cycle, reset RR -> sprite first, tile next; tile_ack once, tile_dout correct.
//  3 dl_active, dl_we addr 0x123, data 0xA55A -> mem_we=1, mem_addr=0x122; pending tile read waits until dl_active=0.
//  4 spr_addr changes 0x5->0x6 while WAIT -> data for 0x5 discarded from output, refetch 0x6, spr_valid only for 0x6.
//  5 SPR_PREFETCH_EN: fetch 0x7FFFF -> prefetch issued at addr 0; spr_addr=0 -> spr_valid next cycle, no mem_req.
//  6 nRES low during ISSUE -> mem_req=0 immediately, all outputs 0; after release, spr_addr refetched.

Source files
------------

// File: rtl/spr_rom_pkg.sv
// Shared types and widths for the sprite/tile ROM scheduler.
package spr_rom_pkg;

    localparam int SPR_AW  = 19;
    localparam int TILE_AW = 20;
    localparam int MEM_AW  = 26;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    typedef enum logic [1:0] {CH_DL, CH_SPR, CH_TILE, CH_PF} chan_t;

    // 32-bit word index to byte address inside a region, wrapping mod 2^26.
    function automatic logic [MEM_AW-1:0] word_addr(input logic [TILE_AW-1:0] w,
                                                    input logic [MEM_AW-1:0] base);
        return {{(MEM_AW-TILE_AW-2){1'b0}}, w, 2'b00} + base;
    endfunction

endpackage

// File: rtl/spr_rom_sched_if.sv
// Request/response port towards the SDRAM controller (one outstanding access).
interface spr_rom_sched_if;
    import spr_rom_pkg::*;

    logic              mem_req;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_ack;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rvalid, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rvalid, mem_rdata);

endinterface

// File: rtl/spr_rom_line.sv
// One cached sprite word: tag, data and a hit compare against the lookup address.
module spr_rom_line
    import spr_rom_pkg::*;
(
    input  logic              clk,
    input  logic              nRES,
    input  logic              inv,
    input  logic              load,
    input  logic [SPR_AW-1:0] load_tag,
    input  logic [31:0]       load_data,
    input  logic [SPR_AW-1:0] lookup,
    output logic              hit,
    output logic [SPR_AW-1:0] tag,
    output logic [31:0]       data
);

    logic              valid_reg;
    logic [SPR_AW-1:0] tag_reg;
    logic [31:0]       data_reg;

    // Invalidation wins over a same-cycle fill: the data is kept but not trusted.
    always_ff @(posedge clk or negedge nRES) begin
        if (!nRES) begin
            valid_reg <= 1'b0;
            tag_reg   <= '0;
            data_reg  <= '0;
        end else begin
            if (load) begin
                tag_reg  <= load_tag;
                data_reg <= load_data;
            end
            if (inv)
                valid_reg <= 1'b0;
            else if (load)
                valid_reg <= 1'b1;
        end
    end

    assign hit  = valid_reg && (tag_reg == lookup);
    assign tag  = tag_reg;
    assign data = data_reg;

endmodule

// File: rtl/spr_rom_sched.sv
// Arbitrates the shared ROM port between download writes, sprite and tile reads.
// Optional SPR_PREFETCH_EN adds a speculative next-word sprite buffer.
module spr_rom_sched
    import spr_rom_pkg::*;
#(
    parameter logic [MEM_AW-1:0] SPR_BASE  = 26'h0100000,
    parameter logic [MEM_AW-1:0] TILE_BASE = 26'h0000000
) (
    input  logic               clk,
    input  logic               nRES,
    input  logic               dl_active,
    input  logic               dl_we,
    input  logic [MEM_AW-1:0]  dl_addr,
    input  logic [15:0]        dl_data,
    output logic               dl_ready,
    input  logic [SPR_AW-1:0]  spr_addr,
    output logic [31:0]        spr_dout,
    output logic               spr_valid,
    input  logic               tile_req,
    input  logic [TILE_AW-1:0] tile_addr,
    output logic [31:0]        tile_dout,
    output logic               tile_ack,
    spr_rom_sched_if.master    mem
);

    state_t            state_reg, state_next;
    chan_t             ch_reg, ch_next;
    logic              we_reg, we_next;
    logic [MEM_AW-1:0] addr_reg, addr_next;
    logic [15:0]       wdata_reg, wdata_next;
    logic [SPR_AW-1:0] itag_reg, itag_next;
    logic              rr_reg, rr_next;
    logic              dl_d_reg, tile_ack_reg;
    logic [31:0]       tile_dout_reg;

    logic              rd_done, spr_fill, dl_fall, spr_pend, tile_pend;
    logic              main_hit, main_load;
    logic [SPR_AW-1:0] main_tag, main_ld_tag;
    logic [31:0]       main_data, main_ld_data;
    logic              dl_lsb_unused;

    assign dl_lsb_unused = dl_addr[0];
    assign rd_done   = (state_reg == WAIT) && mem.mem_rvalid;
    assign spr_fill  = rd_done && (ch_reg == CH_SPR);
    assign dl_fall   = dl_d_reg && !dl_active;
    // The requester still holds tile_req during its ack cycle; do not re-issue it.
    assign tile_pend = tile_req && !tile_ack_reg;

`ifdef SPR_PREFETCH_EN
    logic              pf_hit, pf_load, pf_want_reg, pf_issue, swap;
    logic [SPR_AW-1:0] pf_tag, pf_next_tag;
    logic [31:0]       pf_data;

    assign pf_next_tag  = main_tag + 19'd1;
    assign swap         = pf_hit && !main_hit && !rd_done;
    assign pf_load      = swap || (rd_done && (ch_reg == CH_PF));
    assign main_load    = spr_fill || swap;
    assign main_ld_tag  = swap ? pf_tag  : itag_reg;
    assign main_ld_data = swap ? pf_data : mem.mem_rdata;
    assign spr_pend     = !main_hit && !pf_hit;

    spr_rom_line u_pf (
        .clk       (clk),
        .nRES      (nRES),
        .inv       (dl_fall),
        .load      (pf_load),
        .load_tag  (swap ? main_tag  : itag_reg),
        .load_data (swap ? main_data : mem.mem_rdata),
        .lookup    (spr_addr),
        .hit       (pf_hit),
        .tag       (pf_tag),
        .data      (pf_data)
    );

    always_ff @(posedge clk or negedge nRES) begin
        if (!nRES)
            pf_want_reg <= 1'b0;
        else if (dl_fall)
            pf_want_reg <= 1'b0;
        else if (spr_fill)
            pf_want_reg <= 1'b1;
        else if (pf_issue)
            pf_want_reg <= 1'b0;
    end
`else
    logic main_tag_unused;
    assign main_tag_unused = ^main_tag;
    assign main_load    = spr_fill;
    assign main_ld_tag  = itag_reg;
    assign main_ld_data = mem.mem_rdata;
    assign spr_pend     = !main_hit;
`endif

    spr_rom_line u_main (
        .clk       (clk),
        .nRES      (nRES),
        .inv       (dl_fall),
        .load      (main_load),
        .load_tag  (main_ld_tag),
        .load_data (main_ld_data),
        .lookup    (spr_addr),
        .hit       (main_hit),
        .tag       (main_tag),
        .data      (main_data)
    );

    always_comb begin
        state_next = state_reg;
        ch_next    = ch_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        itag_next  = itag_reg;
        rr_next    = rr_reg;
`ifdef SPR_PREFETCH_EN
        pf_issue   = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (dl_active) begin
                    if (dl_we) begin
                        state_next = ISSUE;
                        ch_next    = CH_DL;
                        we_next    = 1'b1;
                        addr_next  = {dl_addr[MEM_AW-1:1], 1'b0};
                        wdata_next = dl_data;
                    end
                end else if (spr_pend && !(tile_pend && rr_reg)) begin
                    state_next = ISSUE;
                    ch_next    = CH_SPR;
                    we_next    = 1'b0;
                    addr_next  = word_addr({1'b0, spr_addr}, SPR_BASE);
                    itag_next  = spr_addr;
                    rr_next    = 1'b1;
                end else if (tile_pend) begin
                    state_next = ISSUE;
                    ch_next    = CH_TILE;
                    we_next    = 1'b0;
                    addr_next  = word_addr(tile_addr, TILE_BASE);
                    rr_next    = 1'b0;
                end
`ifdef SPR_PREFETCH_EN
                else if (pf_want_reg && !tile_req) begin
                    state_next = ISSUE;
                    ch_next    = CH_PF;
                    we_next    = 1'b0;
                    addr_next  = word_addr({1'b0, pf_next_tag}, SPR_BASE);
                    itag_next  = pf_next_tag;
                    pf_issue   = 1'b1;
                end
`endif
            end
            ISSUE:   if (mem.mem_ack) state_next = we_reg ? IDLE : WAIT;
            WAIT:    if (mem.mem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRES) begin
        if (!nRES) begin
            state_reg     <= IDLE;
            ch_reg        <= CH_DL;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            itag_reg      <= '0;
            rr_reg        <= 1'b0;
            dl_d_reg      <= 1'b0;
            tile_ack_reg  <= 1'b0;
            tile_dout_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ch_reg       <= ch_next;
            we_reg       <= we_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            itag_reg     <= itag_next;
            rr_reg       <= rr_next;
            dl_d_reg     <= dl_active;
            tile_ack_reg <= rd_done && (ch_reg == CH_TILE) && tile_req;
            if (rd_done && (ch_reg == CH_TILE))
                tile_dout_reg <= mem.mem_rdata;
        end
    end

    assign mem.mem_req   = (state_reg == ISSUE);
    assign mem.mem_we    = we_reg;
    assign mem.mem_addr  = addr_reg;
    assign mem.mem_wdata = wdata_reg;
    assign dl_ready      = (state_reg == IDLE) && dl_active;
    assign spr_dout      = main_data;
    assign spr_valid     = main_hit;
    assign tile_dout     = tile_dout_reg;
    assign tile_ack      = tile_ack_reg;

endmodule

// File: tb/tb_spr_rom_sched.sv
// Directed bench for spr_rom_sched with a reference ROM and a behavioural memory port.
module tb_spr_rom_sched;

    typedef struct {
        logic        we;
        logic [25:0] addr;
        logic [15:0] wdata;
    } txn_t;

    logic        clk, nRES;
    logic        dl_active, dl_we, dl_ready;
    logic [25:0] dl_addr;
    logic [15:0] dl_data;
    logic [18:0] spr_addr;
    logic [31:0] spr_dout, tile_dout;
    logic        spr_valid, tile_req, tile_ack;
    logic [19:0] tile_addr;

    int   checks = 0;
    int   failures = 0;
    int   tile_ack_cnt = 0;
    txn_t txn_q[$];
    logic [31:0] rom_ovr [logic [25:0]];

    spr_rom_sched_if m ();

    spr_rom_sched dut (
        .clk       (clk),
        .nRES      (nRES),
        .dl_active (dl_active),
        .dl_we     (dl_we),
        .dl_addr   (dl_addr),
        .dl_data   (dl_data),
        .dl_ready  (dl_ready),
        .spr_addr  (spr_addr),
        .spr_dout  (spr_dout),
        .spr_valid (spr_valid),
        .tile_req  (tile_req),
        .tile_addr (tile_addr),
        .tile_dout (tile_dout),
        .tile_ack  (tile_ack),
        .mem       (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [25:0] a);
        if (rom_ovr.exists(a)) return rom_ovr[a];
        return {6'h2A, a} ^ 32'h5A00_3C00;
    endfunction

    function automatic logic [25:0] spr_byte(input logic [18:0] a);
        return {5'd0, a, 2'b00} + 26'h0100000;
    endfunction

    function automatic logic [25:0] tile_byte(input logic [19:0] a);
        return {4'd0, a, 2'b00};
    endfunction

    function automatic int find_txn(input logic [25:0] a);
        foreach (txn_q[i]) if (!txn_q[i].we && txn_q[i].addr == a) return i;
        return -1;
    endfunction

    function automatic logic [31:0] txn_addr(input int i);
        if (i >= txn_q.size()) return 32'hFFFF_FFFF;
        return {6'd0, txn_q[i].addr};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_spr(input string name);
        int n = 0;
        while (!spr_valid && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_spr_valid_timeout"}, spr_valid, 1);
    endtask

    task automatic wait_tile(input string name);
        int n = 0;
        while (!tile_ack && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_tile_ack_timeout"}, tile_ack, 1);
        @(negedge clk);
        tile_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Memory port: ack in the request cycle, read data one cycle after the ack.
    initial begin
        logic        rd_pend;
        logic [25:0] rd_addr;
        txn_t        t;
        rd_pend = 1'b0;
        rd_addr = '0;
        m.mem_ack = 1'b0;
        m.mem_rvalid = 1'b0;
        m.mem_rdata = '0;
        forever begin
            @(negedge clk);
            m.mem_rvalid = 1'b0;
            if (!nRES) begin
                m.mem_ack = 1'b0;
                rd_pend = 1'b0;
            end else begin
                if (rd_pend) begin
                    m.mem_rvalid = 1'b1;
                    m.mem_rdata = rom_word(rd_addr);
                    rd_pend = 1'b0;
                end
                if (m.mem_ack) begin
                    m.mem_ack = 1'b0;
                end else if (m.mem_req) begin
                    m.mem_ack = 1'b1;
                    t.we = m.mem_we;
                    t.addr = m.mem_addr;
                    t.wdata = m.mem_wdata;
                    txn_q.push_back(t);
                    $display("TXN t=%0t we=%0d addr=%h wdata=%h", $time, t.we, t.addr, t.wdata);
                    if (!m.mem_we) begin
                        rd_pend = 1'b1;
                        rd_addr = m.mem_addr;
                    end
                end
            end
        end
    end

    // Output model: any valid sprite/tile word must be the ROM word of the presented address.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (nRES && spr_valid)
                chk("spr_model", spr_dout, rom_word(spr_byte(spr_addr)));
            if (nRES && tile_ack) begin
                tile_ack_cnt++;
                chk("tile_model", tile_dout, rom_word(tile_byte(tile_addr)));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic v2, v3;
        int   nw, wi, n0;
        nRES = 1'b0; dl_active = 1'b0; dl_we = 1'b0; dl_addr = '0; dl_data = '0;
        spr_addr = 19'h00020; tile_req = 1'b1; tile_addr = 20'h00033;
        rom_ovr[26'h0100040] = 32'hDEADBEEF;
        v2 = 1'b0; v3 = 1'b0; nw = 0; wi = 0;

        repeat (3) @(posedge clk); #1;
        chk("rst_mem_req", m.mem_req, 0);
        chk("rst_mem_addr", m.mem_addr, 0);
        chk("rst_spr_valid", spr_valid, 0);
        chk("rst_spr_dout", spr_dout, 0);
        chk("rst_tile_ack", tile_ack, 0);
        @(negedge clk);
        nRES = 1'b1;

        // Sprite and tile requested together out of reset: sprite wins, tile follows.
        wait_tile("t2");
        idle(10);
        chk("t2_spr_first", find_txn(26'h0100080), 0);
        chk("t2_tile_second", find_txn(26'h00000CC), 1);
        chk("t2_ack_count", tile_ack_cnt, 1);
        chk("t2_spr_valid", spr_valid, 1);
        chk("t2_spr_dout", spr_dout, rom_word(26'h0100080));

        // Address-driven sprite fetch, valid three edges after the change.
        txn_q.delete();
        @(negedge clk);
        spr_addr = 19'h00010;
        #1 chk("t1_valid_drop", spr_valid, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 2) v2 = spr_valid;
            if (k == 3) v3 = spr_valid;
        end
        chk("t1_valid_p2", v2, 0);
        chk("t1_valid_p3", v3, 1);
        chk("t1_spr_dout", spr_dout, 32'hDEADBEEF);
        chk("t1_mem_addr", txn_addr(0), 32'h0100040);

        // Download holds off reads; a dl_we while busy is dropped.
        idle(10);
        txn_q.delete();
        @(negedge clk);
        dl_active = 1'b1; tile_addr = 20'h00044; tile_req = 1'b1;
        @(posedge clk); #1;
        chk("t3_dl_ready", dl_ready, 1);
        idle(4);
        dl_we = 1'b1; dl_addr = 26'h0000123; dl_data = 16'hA55A;
        @(negedge clk);
        chk("t3_ready_busy", dl_ready, 0);
        dl_addr = 26'h0000200; dl_data = 16'h1111;
        @(negedge clk);
        dl_we = 1'b0;
        idle(6);
        foreach (txn_q[i]) if (txn_q[i].we) begin nw++; wi = i; end
        chk("t3_wr_count", nw, 1);
        chk("t3_wr_addr", txn_addr(wi), 32'h0000122);
        chk("t3_wr_data", {16'd0, txn_q[wi].wdata}, 32'h0000A55A);
        chk("t3_no_read", txn_q.size(), 1);
        @(negedge clk);
        dl_active = 1'b0;
        wait_tile("t3");
        idle(15);
        chk("t3_tile_addr", txn_addr(1), 32'h0000110);
        chk("t3_spr_refetch", find_txn(26'h0100040), 2);
        chk("t3_spr_valid", spr_valid, 1);

        // Address moves while the read is in flight: stale word stored but never valid.
        idle(5);
        txn_q.delete();
        @(negedge clk);
        spr_addr = 19'h00005;
        @(negedge clk);
        @(negedge clk);
        spr_addr = 19'h00006;
        @(posedge clk); #1;
        chk("t4_valid_stale", spr_valid, 0);
        chk("t4_stale_data", spr_dout, rom_word(26'h0100014));
        wait_spr("t4");
        chk("t4_spr_dout", spr_dout, rom_word(26'h0100018));
        chk("t4_first_addr", txn_addr(0), 32'h0100014);
        chk("t4_refetch_addr", find_txn(26'h0100018), 1);

`ifdef SPR_PREFETCH_EN
        // Prefetch wraps past the last sprite word and serves the next access locally.
        idle(5);
        txn_q.delete();
        @(negedge clk);
        spr_addr = 19'h7FFFF;
        wait_spr("t5");
        idle(10);
        chk("t5_pf_addr", find_txn(26'h0100000), 1);
        n0 = txn_q.size();
        @(negedge clk);
        spr_addr = 19'h00000;
        @(posedge clk); #1;
        chk("t5_pf_valid", spr_valid, 1);
        chk("t5_pf_dout", spr_dout, rom_word(26'h0100000));
        idle(10);
        chk("t5_no_mem", txn_q.size(), n0);
`else
        n0 = 0;
`endif

        // Reset while a request is outstanding.
        idle(5);
        txn_q.delete();
        @(negedge clk);
        spr_addr = 19'h00007;
        @(posedge clk); #1;
        chk("t6_req_issue", m.mem_req, 1);
        nRES = 1'b0;
        #1;
        chk("t6_req_drop", m.mem_req, 0);
        chk("t6_mem_addr", m.mem_addr, 0);
        chk("t6_spr_valid", spr_valid, 0);
        chk("t6_spr_dout", spr_dout, 0);
        chk("t6_tile_dout", tile_dout, 0);
        @(negedge clk);
        @(negedge clk);
        nRES = 1'b1;
        wait_spr("t6");
        chk("t6_refetch_addr", txn_addr(0), 32'h010001C);
        chk("t6_spr_dout_after", spr_dout, rom_word(26'h010001C));
        chk("total_tile_acks", tile_ack_cnt, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
